// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace buffer: FSM state encoding, trigger
// modes and the status-compare helper.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam logic [1:0] TRIG_NONE   = 2'd0;
  localparam logic [1:0] TRIG_PC     = 2'd1;
  localparam logic [1:0] TRIG_STATUS = 2'd2;
  localparam logic [1:0] TRIG_MANUAL = 2'd3;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned STATUS_W = 4;

  function automatic logic status_match(input logic [STATUS_W-1:0] st,
                                        input logic [STATUS_W-1:0] cmp,
                                        input logic [STATUS_W-1:0] mask);
    return ((st & mask) == (cmp & mask));
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the controller.
module trace_ram #(
  parameter int unsigned WIDTH = 164,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular CPU trace buffer: captures qualified samples while armed, stops a
// fixed number of samples after a trigger, then drains oldest-first.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cap_en,
  input  logic [DATA_W-1:0]          pc,
  input  logic [31:0]                instr,
  input  logic [DATA_W-1:0]          alu_out,
  input  logic [3:0]                 status,
  input  logic                       arm,
  input  logic [1:0]                 trig_mode,
  input  logic [DATA_W-1:0]          trig_pc,
  input  logic [3:0]                 trig_status,
  input  logic [3:0]                 trig_mask,
  input  logic                       trig_manual,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_pc,
  output logic [31:0]                rd_instr,
  output logic [DATA_W-1:0]          rd_alu,
  output logic [3:0]                 rd_status,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned CW        = $clog2(DEPTH+1);
  localparam int unsigned EW        = 2*DATA_W + INSTR_W + STATUS_W;
  localparam int unsigned ALU_LSB   = STATUS_W;
  localparam int unsigned INSTR_LSB = DATA_W + STATUS_W;
  localparam int unsigned PC_LSB    = DATA_W + INSTR_W + STATUS_W;

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [AW-1:0] POST_LAST = (POST_TRIG == 32'd0) ? '0 : AW'(POST_TRIG - 32'd1);

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] post_q, post_d;
  logic          rd_valid_q, rd_valid_d;

  logic          mode_hit_s;
  logic          trig_hit_s;
  logic          capture_s;
  logic [AW-1:0] rptr_s;
  logic [EW-1:0] wdata_s;
  logic [EW-1:0] rdata_s;

  // Trigger condition selected by mode; only meaningful on a captured sample
  always_comb begin
    mode_hit_s = 1'b0;
    case (trig_mode)
      TRIG_PC:     mode_hit_s = (pc == trig_pc);
      TRIG_STATUS: mode_hit_s = status_match(status, trig_status, trig_mask);
      TRIG_MANUAL: mode_hit_s = trig_manual;
      default:     mode_hit_s = 1'b0;
    endcase
  end

  assign trig_hit_s = cap_en && (state_q == ST_ARMED) && mode_hit_s;

  // Next-state logic for FSM, write pointer, fill count and post-trigger count
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    post_d    = post_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
          wptr_d  = '0;
          count_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // A trigger outranks a concurrent arm, and arm is otherwise ignored here
        if (cap_en) begin
          capture_s = 1'b1;
          wptr_d    = wptr_q + AW'(1);
          count_d   = (count_q == CNT_FULL) ? count_q : count_q + CW'(1);
          if (trig_hit_s) begin
            post_d  = '0;
            state_d = (POST_TRIG == 32'd0) ? ST_DONE : ST_POST;
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_POST: begin
        if (cap_en) begin
          capture_s = 1'b1;
          wptr_d    = wptr_q + AW'(1);
          count_d   = (count_q == CNT_FULL) ? count_q : count_q + CW'(1);
          if (post_q == POST_LAST) begin
            state_d = ST_DONE;
          end else begin
            post_d  = post_q + AW'(1);
          end
        end else begin
          state_d = ST_POST;
        end
      end
      ST_DONE: begin
        if (arm) begin
          state_d = ST_ARMED;
          wptr_d  = '0;
          count_d = '0;
        end else if (rd_valid_q && rd_ready) begin
          count_d = count_q - CW'(1);
          state_d = (count_q == CW'(1)) ? ST_IDLE : ST_DONE;
        end else if (count_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wptr_d  = '0;
        count_d = '0;
        post_d  = '0;
      end
    endcase
    rd_valid_d = (state_d == ST_DONE) && (count_d != '0);
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      count_q    <= '0;
      post_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Oldest entry sits count slots behind the write pointer; a full buffer wraps to wptr itself
  assign rptr_s  = wptr_q - count_q[AW-1:0];
  assign wdata_s = {pc, instr, alu_out, status};

  trace_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (capture_s),
    .waddr_i (wptr_q),
    .wdata_i (wdata_s),
    .raddr_i (rptr_s),
    .rdata_o (rdata_s)
  );

  // Readout fields are forced to zero whenever no entry is being offered
  always_comb begin
    if (rd_valid_q) begin
      rd_pc     = rdata_s[PC_LSB +: DATA_W];
      rd_instr  = rdata_s[INSTR_LSB +: INSTR_W];
      rd_alu    = rdata_s[ALU_LSB +: DATA_W];
      rd_status = rdata_s[0 +: STATUS_W];
    end else begin
      rd_pc     = '0;
      rd_instr  = '0;
      rd_alu    = '0;
      rd_status = '0;
    end
  end

  assign rd_valid = rd_valid_q;
  assign state    = state_q;
  assign count    = count_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: scenario table plus randomized traffic, checked
// every cycle against a queue-based model of the trace rules.
module tb_cpu_trace_buffer;

  localparam int DATA_W    = 64;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        cap_en, arm, trig_manual, rd_ready, rd_valid;
  logic [63:0] pc, alu_out, trig_pc, rd_pc, rd_alu;
  logic [31:0] instr, rd_instr;
  logic [3:0]  status, trig_status, trig_mask, rd_status, count;
  logic [1:0]  trig_mode, state;

  cpu_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clock(clock), .reset(reset), .cap_en(cap_en), .pc(pc), .instr(instr),
    .alu_out(alu_out), .status(status), .arm(arm), .trig_mode(trig_mode),
    .trig_pc(trig_pc), .trig_status(trig_status), .trig_mask(trig_mask),
    .trig_manual(trig_manual), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_alu(rd_alu), .rd_status(rd_status),
    .state(state), .count(count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] alu;
    logic [3:0]  st;
  } entry_t;

  entry_t mq[$];
  int     m_state = 0;
  int     m_post  = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] tpc;
    logic [3:0]  tst;
    logic [3:0]  tmask;
    int          manual_k;
    int          z_k;
    bit          gap;
    int          arm_a;
    int          arm_b;
    int          stall;
    bit          reset_in_done;
    int          exp_count;
    logic [63:0] exp_first;
  } scn_t;

  scn_t scn[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_post  = 0;
  endtask

  task automatic model_push(input entry_t e);
    mq.push_back(e);
    if (mq.size() > DEPTH) void'(mq.pop_front());
  endtask

  // Applies the trace rules to the inputs the next rising edge will see
  task automatic model_step();
    entry_t e;
    bit hit;
    e = '{pc: pc, instr: instr, alu: alu_out, st: status};
    case (m_state)
      0: if (arm) begin mq.delete(); m_state = 1; end
      1: if (cap_en) begin
        model_push(e);
        case (trig_mode)
          2'd1:    hit = (pc == trig_pc);
          2'd2:    hit = ((status & trig_mask) == (trig_status & trig_mask));
          2'd3:    hit = trig_manual;
          default: hit = 1'b0;
        endcase
        if (hit) begin
          m_post  = 0;
          m_state = (POST_TRIG == 0) ? 3 : 2;
        end
      end
      2: if (cap_en) begin
        model_push(e);
        m_post++;
        if (m_post == POST_TRIG) m_state = 3;
      end
      3: begin
        if (arm) begin
          mq.delete();
          m_state = 1;
        end else if (rd_ready && mq.size() > 0) begin
          void'(mq.pop_front());
          if (mq.size() == 0) m_state = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    bit exp_v;
    chk("state", {62'd0, state}, 64'(m_state));
    chk("count", {60'd0, count}, 64'(mq.size()));
    exp_v = (m_state == 3) && (mq.size() > 0);
    chk("rd_valid", {63'd0, rd_valid}, {63'd0, exp_v});
    if (exp_v) begin
      chk("rd_pc", rd_pc, mq[0].pc);
      chk("rd_instr", {32'd0, rd_instr}, {32'd0, mq[0].instr});
      chk("rd_alu", rd_alu, mq[0].alu);
      chk("rd_status", {60'd0, rd_status}, {60'd0, mq[0].st});
    end
  endtask

  // Called at a falling edge with inputs set: model, edge, then compare
  task automatic tick();
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge
  task automatic reset_mid();
    #2 reset = 1'b0;
    #1;
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_count", {60'd0, count}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_pc", rd_pc, 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drive_sample(input int k, input logic [3:0] st);
    cap_en  = 1'b1;
    pc      = 64'(4 * k);
    instr   = 32'hA500_0000 ^ 32'(k);
    alu_out = ~(64'(4 * k));
    status  = st;
  endtask

  task automatic run_scn(input int idx, input scn_t s);
    int k;
    trig_mode = s.mode; trig_pc = s.tpc; trig_status = s.tst; trig_mask = s.tmask;
    trig_manual = 1'b0; rd_ready = 1'b0; cap_en = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (m_state == 3) break;
      if (s.gap && (cyc % 2 == 1)) begin
        // Idle cycle carrying values that would trigger if it were sampled
        cap_en = 1'b0; pc = 64'h28; status = 4'b0100; trig_manual = 1'b1; arm = 1'b0;
      end else begin
        drive_sample(k, (k == s.z_k) ? 4'b0100 : 4'b1011);
        trig_manual = (k == s.manual_k);
        arm = (k == s.arm_a) || (k == s.arm_b);
      end
      tick();
      if (cap_en) k++;
    end
    cap_en = 1'b0; arm = 1'b0; trig_manual = 1'b0;
    chk($sformatf("scn%0d_done", idx), {62'd0, state}, 64'd3);
    chk($sformatf("scn%0d_count", idx), {60'd0, count}, 64'(s.exp_count));
    chk($sformatf("scn%0d_first_pc", idx), rd_pc, s.exp_first);
    if (s.reset_in_done) begin
      reset_mid();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("post_reset_count", {60'd0, count}, 64'd0);
      chk("post_reset_state", {62'd0, state}, 64'd1);
      return;
    end
    for (int i = 0; i < s.stall; i++) begin
      tick();
      chk($sformatf("scn%0d_stall_pc", idx), rd_pc, s.exp_first);
      chk($sformatf("scn%0d_stall_cnt", idx), {60'd0, count}, 64'(s.exp_count));
      chk($sformatf("scn%0d_stall_valid", idx), {63'd0, rd_valid}, 64'd1);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < s.exp_count; i++) begin
      chk($sformatf("scn%0d_drain_pc", idx), rd_pc, s.exp_first + 64'(4 * i));
      tick();
    end
    rd_ready = 1'b0;
    chk($sformatf("scn%0d_end_state", idx), {62'd0, state}, 64'd0);
    chk($sformatf("scn%0d_end_valid", idx), {63'd0, rd_valid}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            mode   tpc    tst      tmask    man  z   gap  armA armB stall rst cnt first
    scn[0] = '{2'd1, 64'h28, 4'b0000, 4'b0000, -1, -1, 1'b0, -1, -1, 0, 1'b0, 8, 64'h18};
    scn[1] = '{2'd3, 64'h00, 4'b0000, 4'b0000,  2, -1, 1'b0, -1, -1, 0, 1'b0, 6, 64'h00};
    scn[2] = '{2'd1, 64'h28, 4'b0000, 4'b0000, -1, -1, 1'b1, -1, -1, 0, 1'b0, 8, 64'h18};
    scn[3] = '{2'd1, 64'h28, 4'b0000, 4'b0000, -1, -1, 1'b0, -1, -1, 5, 1'b0, 8, 64'h18};
    scn[4] = '{2'd2, 64'h00, 4'b0100, 4'b0100, -1,  5, 1'b0,  3,  6, 0, 1'b0, 8, 64'h04};
    scn[5] = '{2'd1, 64'h28, 4'b0000, 4'b0000, -1, -1, 1'b0, -1, -1, 0, 1'b1, 8, 64'h18};

    reset = 1'b0;
    cap_en = 1'b0; arm = 1'b0; trig_manual = 1'b0; rd_ready = 1'b0;
    pc = '0; instr = '0; alu_out = '0; status = '0;
    trig_mode = 2'd0; trig_pc = '0; trig_status = '0; trig_mask = '0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("init_state", {62'd0, state}, 64'd0);
    chk("init_count", {60'd0, count}, 64'd0);
    chk("init_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("init_rd_pc", rd_pc, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_scn(i, scn[i]);

    // Randomized traffic; resets land in arbitrary states
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 50 == 0) trig_pc = 64'(4 * $urandom_range(0, 15));
      cap_en      = ($urandom_range(0, 3) != 0);
      pc          = 64'(4 * $urandom_range(0, 15));
      instr       = $urandom();
      alu_out     = {$urandom(), $urandom()};
      status      = 4'($urandom());
      arm         = ($urandom_range(0, 7) == 0);
      trig_mode   = 2'($urandom());
      trig_status = 4'($urandom());
      trig_mask   = 4'($urandom());
      trig_manual = ($urandom_range(0, 15) == 0);
      rd_ready    = ($urandom_range(0, 1) == 1);
      if (cyc % 400 == 399) reset_mid();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
